kw_pipe_elastic: RTL and testbench



---
 rtl/kw_dp_pkg.sv | 14 +
 rtl/kw_pipe_elastic_stage.sv | 53 +++++
 rtl/kw_pipe_elastic.sv | 151 +++++++++++++++
 tb/tb_kw_pipe_elastic.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kw_dp_pkg.sv
// -----------------------------------------------------------------------------
// kw_dp_pkg
// Shared datapath-library helpers.
//   kw_cnt_w(depth) : width of an occupancy counter for a pipe of `depth`
//                     stages plus an optional one-entry skid buffer
//                     (values 0 .. depth+1).
// -----------------------------------------------------------------------------
package kw_dp_pkg;

  function automatic int kw_cnt_w(int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/kw_pipe_elastic_stage.sv
// -----------------------------------------------------------------------------
// kw_pipe_elastic_stage
// One valid/data stage of the elastic pipe. The stage loads whenever it is
// empty or its current beat moves on downstream, so bubbles collapse.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset (valid and data cleared)
//   i_flush    : synchronous clear of the valid bit (data kept)
//   i_src_v    : valid of the upstream source feeding this stage
//   i_src_d    : payload of the upstream source
//   i_adv_nxt  : downstream stage advances (or consumer ready, for the last)
//   o_v        : stage holds a beat
//   o_d        : stage payload
//   o_adv      : stage advances this cycle (empty or draining)
// -----------------------------------------------------------------------------
module kw_pipe_elastic_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_src_v,
  input  logic [DATA_WIDTH-1:0] i_src_d,
  input  logic                  i_adv_nxt,
  output logic                  o_v,
  output logic [DATA_WIDTH-1:0] o_d,
  output logic                  o_adv
);

  logic                  r_v;
  logic [DATA_WIDTH-1:0] r_d;

  assign o_adv = ~r_v | i_adv_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else begin
      if (i_flush)
        r_v <= 1'b0;
      else if (o_adv)
        r_v <= i_src_v;
      // Payload only moves with a real beat; bubbles and flushes leave it alone.
      if (!i_flush && o_adv && i_src_v)
        r_d <= i_src_d;
    end
  end

  assign o_v = r_v;
  assign o_d = r_d;

endmodule

// File: rtl/kw_pipe_elastic.sv
// -----------------------------------------------------------------------------
// kw_pipe_elastic
// Elastic pipeline register: DEPTH valid/data stages with valid/ready
// handshake, bubble collapsing, synchronous flush and occupancy count.
// SKID=1 adds a one-entry input skid buffer so in_ready comes from a flop.
// Ports:
//   clock      : sole clock, rising edge
//   reset      : synchronous active-high reset
//   flush      : synchronous clear of all valid bits
//   in_valid   : upstream beat present
//   in_ready   : block accepts the beat this cycle
//   in_data    : upstream payload
//   out_valid  : last stage holds a beat
//   out_ready  : downstream accepts this cycle
//   out_data   : payload of the last stage
//   count      : beats currently held (stages plus skid)
// -----------------------------------------------------------------------------
module kw_pipe_elastic
  import kw_dp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int SKID       = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [kw_cnt_w(DEPTH)-1:0]    count
);

  localparam int CW = kw_cnt_w(DEPTH);

  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_src_v;
  logic [DATA_WIDTH-1:0] w_src_d;
  logic                  w_adv0;
  logic                  w_last_v;
  logic [DATA_WIDTH-1:0] w_last_d;
  logic [CW-1:0]         r_count;

  // Each stage keeps its own nets so the adv chain is a plain combinational
  // path from the output back to stage 0.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic                  w_v_i;
    logic [DATA_WIDTH-1:0] w_d_i;
    logic                  w_adv_i;
    logic                  w_adv_nxt_i;
    logic                  w_src_v_i;
    logic [DATA_WIDTH-1:0] w_src_d_i;

    if (i == DEPTH - 1) begin : g_last
      assign w_adv_nxt_i = out_ready;
    end else begin : g_mid
      assign w_adv_nxt_i = g_stage[i+1].w_adv_i;
    end

    if (i == 0) begin : g_first
      assign w_src_v_i = w_src_v;
      assign w_src_d_i = w_src_d;
    end else begin : g_chain
      assign w_src_v_i = g_stage[i-1].w_v_i;
      assign w_src_d_i = g_stage[i-1].w_d_i;
    end

    kw_pipe_elastic_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .i_clk     (clock),
      .i_rst     (reset),
      .i_flush   (flush),
      .i_src_v   (w_src_v_i),
      .i_src_d   (w_src_d_i),
      .i_adv_nxt (w_adv_nxt_i),
      .o_v       (w_v_i),
      .o_d       (w_d_i),
      .o_adv     (w_adv_i)
    );
  end

  assign w_adv0   = g_stage[0].w_adv_i;
  assign w_last_v = g_stage[DEPTH-1].w_v_i;
  assign w_last_d = g_stage[DEPTH-1].w_d_i;

  if (SKID != 0) begin : g_skid
    logic                  r_skid_v;
    logic [DATA_WIDTH-1:0] r_skid_d;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_skid_v <= 1'b0;
        r_skid_d <= '0;
      end else if (flush) begin
        r_skid_v <= 1'b0;
      end else if (r_skid_v) begin
        // in_ready is low while parked, so no new beat can collide here.
        if (w_adv0)
          r_skid_v <= 1'b0;
      end else if (w_in_xfer && !w_adv0) begin
        r_skid_v <= 1'b1;
        r_skid_d <= in_data;
      end
    end

    assign in_ready = ~r_skid_v & ~flush & ~reset;
    // Parked beat is older than anything on in_data, so it goes first.
    assign w_src_v  = r_skid_v | w_in_xfer;
    assign w_src_d  = r_skid_v ? r_skid_d : in_data;
  end else begin : g_noskid
    assign in_ready = w_adv0 & ~flush & ~reset;
    assign w_src_v  = w_in_xfer;
    assign w_src_d  = in_data;
  end

  assign w_in_xfer  = in_valid & in_ready;
  assign out_valid  = w_last_v & ~reset;
  assign out_data   = reset ? '0 : w_last_d;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;

`ifndef SYNTHESIS
  a_count_max: assert property (@(posedge clock) disable iff (reset)
    int'(count) <= DEPTH + SKID);

  a_no_in_flush: assert property (@(posedge clock)
    !(flush && in_valid && in_ready));

  a_out_stable: assert property (@(posedge clock) disable iff (reset)
    (out_valid && !out_ready) |=> $stable(out_data));
`endif

endmodule

// File: tb/tb_kw_pipe_elastic.sv
// -----------------------------------------------------------------------------
// tb_kw_pipe_elastic
// Bench for kw_pipe_elastic. Nine instances with different DEPTH/SKID share
// clock, reset and flush; each has its own handshake signals.
//   0: D3 S0   1: D4 S0   2: D4 S1   3: D1 S0   4: D1 S1
//   5: D2 S0   6: D2 S1   7: D5 S0   8: D5 S1
// Inputs are driven 1 time unit after the rising edge, outputs sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_kw_pipe_elastic;
  import kw_dp_pkg::*;

  localparam int N = 9;

  function automatic int cfg_depth(input int k);
    case (k)
      0:       return 3;
      1, 2:    return 4;
      3, 4:    return 1;
      5, 6:    return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int cfg_skid(input int k);
    return (k == 2 || k == 4 || k == 6 || k == 8) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       fl;
  logic       iv   [N];
  logic       ordy [N];
  logic [7:0] id   [N];
  logic       ir   [N];
  logic       ov   [N];
  logic [7:0] od   [N];
  logic [2:0] cnt  [N];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D = cfg_depth(g);
    localparam int S = cfg_skid(g);
    logic                    w_ir;
    logic                    w_ov;
    logic [7:0]              w_od;
    logic [kw_cnt_w(D)-1:0]  w_cnt;

    kw_pipe_elastic #(
      .DATA_WIDTH (8),
      .DEPTH      (D),
      .SKID       (S)
    ) u_dut (
      .clock     (clk),
      .reset     (rst),
      .flush     (fl),
      .in_valid  (iv[g]),
      .in_ready  (w_ir),
      .in_data   (id[g]),
      .out_valid (w_ov),
      .out_ready (ordy[g]),
      .out_data  (w_od),
      .count     (w_cnt)
    );

    assign ir[g]  = w_ir;
    assign ov[g]  = w_ov;
    assign od[g]  = w_od;
    assign cnt[g] = 3'(w_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
      id[k]   = 8'h00;
    end
    fl = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv[0] = 1'b1;
    id[0] = 8'hE1;
    tick();
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b0) begin errors++; $display("FAIL rst_in_ready[%0d]: got %b want 0", k, ir[k]); end
      checks++;
      if (ov[k] !== 1'b0) begin errors++; $display("FAIL rst_out_valid[%0d]: got %b want 0", k, ov[k]); end
      checks++;
      if (od[k] !== 8'h00) begin errors++; $display("FAIL rst_out_data[%0d]: got %h want 00", k, od[k]); end
    end
    tick();
    rst = 1'b0;
    iv[0] = 1'b0;
    sample();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ir[k] !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready[%0d]: got %b want 1", k, ir[k]); end
      checks++;
      if (cnt[k] !== 3'd0) begin errors++; $display("FAIL post_rst_count[%0d]: got %0d want 0", k, cnt[k]); end
      checks++;
      if (ov[k] !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid[%0d]: got %b want 0", k, ov[k]); end
    end
    tick();
  endtask

  // DEPTH=3, SKID=0: 0x01..0x0A streamed with out_ready held high.
  task automatic test_stream();
    logic       exp_v;
    logic [2:0] exp_cnt;
    do_reset();
    ordy[0] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      iv[0] = (c < 10);
      id[0] = 8'(c + 1);
      sample();
      exp_v   = (c >= 3 && c <= 12);
      exp_cnt = (c <= 10) ? ((c < 3) ? 3'(c) : 3'd3) : 3'(13 - c);
      if (c < 10) begin
        checks++;
        if (ir[0] !== 1'b1) begin errors++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, ir[0]); end
      end
      checks++;
      if (ov[0] !== exp_v) begin errors++; $display("FAIL stream_out_valid c%0d: got %b want %b", c, ov[0], exp_v); end
      if (exp_v) begin
        checks++;
        if (od[0] !== 8'(c - 2)) begin errors++; $display("FAIL stream_out_data c%0d: got %h want %h", c, od[0], 8'(c - 2)); end
      end
      checks++;
      if (cnt[0] !== exp_cnt) begin errors++; $display("FAIL stream_count c%0d: got %0d want %0d", c, cnt[0], exp_cnt); end
      tick();
    end
    idle_all();
  endtask

  // DEPTH=4 with and without skid: fill against out_ready=0, then drain.
  task automatic test_backpressure();
    int nxt [N];
    int got [N];
    do_reset();
    for (int k = 0; k < N; k++) begin nxt[k] = 0; got[k] = 0; end
    for (int c = 0; c < 9; c++) begin
      for (int k = 1; k <= 2; k++) begin
        iv[k] = (nxt[k] < 6);
        id[k] = 8'(8'h10 + nxt[k]);
      end
      sample();
      for (int k = 1; k <= 2; k++)
        if (iv[k] && ir[k]) nxt[k]++;
      tick();
    end
    for (int k = 1; k <= 2; k++) begin
      iv[k] = (nxt[k] < 6);
      id[k] = 8'(8'h10 + nxt[k]);
    end
    sample();
    checks++;
    if (nxt[1] !== 4) begin errors++; $display("FAIL bp_accepted_s0: got %0d want 4", nxt[1]); end
    checks++;
    if (nxt[2] !== 5) begin errors++; $display("FAIL bp_accepted_s1: got %0d want 5", nxt[2]); end
    checks++;
    if (cnt[1] !== 3'd4) begin errors++; $display("FAIL bp_count_s0: got %0d want 4", cnt[1]); end
    checks++;
    if (cnt[2] !== 3'd5) begin errors++; $display("FAIL bp_count_s1: got %0d want 5", cnt[2]); end
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if (ir[k] !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready[%0d]: got %b want 0", k, ir[k]); end
      checks++;
      if (od[k] !== 8'h10 || ov[k] !== 1'b1) begin
        errors++; $display("FAIL bp_full_head[%0d]: got v=%b d=%h want v=1 d=10", k, ov[k], od[k]);
      end
    end
    tick();
    ordy[1] = 1'b1;
    ordy[2] = 1'b1;
    for (int d = 0; d < 14; d++) begin
      for (int k = 1; k <= 2; k++) begin
        iv[k] = (nxt[k] < 6);
        id[k] = 8'(8'h10 + nxt[k]);
      end
      sample();
      if (d == 0) begin
        checks++;
        if (ir[1] !== 1'b1) begin errors++; $display("FAIL bp_s0_ready_same_cycle: got %b want 1", ir[1]); end
        checks++;
        if (ir[2] !== 1'b0) begin errors++; $display("FAIL bp_s1_ready_first_cycle: got %b want 0", ir[2]); end
      end
      if (d == 1) begin
        checks++;
        if (ir[2] !== 1'b1) begin errors++; $display("FAIL bp_s1_ready_after_drain: got %b want 1", ir[2]); end
      end
      for (int k = 1; k <= 2; k++) begin
        if (iv[k] && ir[k]) nxt[k]++;
        if (ov[k] && ordy[k]) begin
          checks++;
          if (od[k] !== 8'(8'h10 + got[k])) begin
            errors++; $display("FAIL bp_drain_order[%0d]: got %h want %h", k, od[k], 8'(8'h10 + got[k]));
          end
          got[k]++;
        end
      end
      tick();
    end
    iv[1] = 1'b0;
    iv[2] = 1'b0;
    sample();
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if (got[k] !== 6) begin errors++; $display("FAIL bp_drained_total[%0d]: got %0d want 6", k, got[k]); end
      checks++;
      if (cnt[k] !== 3'd0 || ov[k] !== 1'b0) begin
        errors++; $display("FAIL bp_empty[%0d]: got cnt=%0d v=%b want cnt=0 v=0", k, cnt[k], ov[k]);
      end
    end
    tick();
    idle_all();
  endtask

  // DEPTH=4: 0xAA, two idle cycles, 0xBB, out_ready low; beats must end up
  // adjacent, so they leave on consecutive cycles.
  task automatic test_bubble();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      iv[1] = (c == 0 || c == 3);
      id[1] = (c == 0) ? 8'hAA : 8'hBB;
      sample();
      if (c == 0 || c == 3) begin
        checks++;
        if (ir[1] !== 1'b1) begin errors++; $display("FAIL bubble_in_ready c%0d: got %b want 1", c, ir[1]); end
      end
      tick();
    end
    iv[1] = 1'b0;
    sample();
    checks++;
    if (cnt[1] !== 3'd2) begin errors++; $display("FAIL bubble_count: got %0d want 2", cnt[1]); end
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== 8'hAA) begin
      errors++; $display("FAIL bubble_head: got v=%b d=%h want v=1 d=aa", ov[1], od[1]);
    end
    tick();
    ordy[1] = 1'b1;
    sample();
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== 8'hAA) begin
      errors++; $display("FAIL bubble_out0: got v=%b d=%h want v=1 d=aa", ov[1], od[1]);
    end
    tick();
    sample();
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== 8'hBB) begin
      errors++; $display("FAIL bubble_out1: got v=%b d=%h want v=1 d=bb", ov[1], od[1]);
    end
    tick();
    sample();
    checks++;
    if (ov[1] !== 1'b0 || cnt[1] !== 3'd0) begin
      errors++; $display("FAIL bubble_empty: got v=%b cnt=%0d want v=0 cnt=0", ov[1], cnt[1]);
    end
    tick();
    idle_all();
  endtask

  // DEPTH=3: flush a full pipe while 0x55 is offered.
  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      iv[0] = 1'b1;
      id[0] = 8'(8'h31 + c);
      sample();
      checks++;
      if (ir[0] !== 1'b1) begin errors++; $display("FAIL flush_fill_ready c%0d: got %b want 1", c, ir[0]); end
      tick();
    end
    fl    = 1'b1;
    iv[0] = 1'b1;
    id[0] = 8'h55;
    sample();
    checks++;
    if (ir[0] !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", ir[0]); end
    checks++;
    if (cnt[0] !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", cnt[0]); end
    checks++;
    if (ov[0] !== 1'b1 || od[0] !== 8'h31) begin
      errors++; $display("FAIL flush_pre_head: got v=%b d=%h want v=1 d=31", ov[0], od[0]);
    end
    tick();
    fl      = 1'b0;
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      checks++;
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL flush_out_valid c%0d: got %b d=%h want 0", c, ov[0], od[0]); end
      checks++;
      if (cnt[0] !== 3'd0) begin errors++; $display("FAIL flush_count c%0d: got %0d want 0", c, cnt[0]); end
      tick();
    end
    idle_all();
  endtask

  // DEPTH=4: reset taken with two beats in flight.
  task automatic test_reset_midstream();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      iv[1] = (c < 2);
      id[1] = 8'(8'h71 + c);
      tick();
    end
    iv[1] = 1'b0;
    sample();
    checks++;
    if (cnt[1] !== 3'd2) begin errors++; $display("FAIL rstmid_count: got %0d want 2", cnt[1]); end
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== 8'h71) begin
      errors++; $display("FAIL rstmid_head: got v=%b d=%h want v=1 d=71", ov[1], od[1]);
    end
    tick();
    rst   = 1'b1;
    iv[1] = 1'b1;
    id[1] = 8'h77;
    sample();
    checks++;
    if (ov[1] !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", ov[1]); end
    checks++;
    if (od[1] !== 8'h00) begin errors++; $display("FAIL rstmid_out_data: got %h want 00", od[1]); end
    checks++;
    if (ir[1] !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b want 0", ir[1]); end
    tick();
    rst     = 1'b0;
    iv[1]   = 1'b0;
    ordy[1] = 1'b1;
    sample();
    checks++;
    if (ir[1] !== 1'b1) begin errors++; $display("FAIL rstmid_rel_in_ready: got %b want 1", ir[1]); end
    checks++;
    if (cnt[1] !== 3'd0) begin errors++; $display("FAIL rstmid_rel_count: got %0d want 0", cnt[1]); end
    checks++;
    if (od[1] !== 8'h00) begin errors++; $display("FAIL rstmid_rel_data: got %h want 00", od[1]); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ov[1] !== 1'b0) begin errors++; $display("FAIL rstmid_no_survivor c%0d: got %b d=%h want 0", c, ov[1], od[1]); end
      tick();
      sample();
    end
    tick();
    idle_all();
  endtask

  // All instances: random in_valid/out_ready at 50%, scoreboard per instance.
  task automatic test_random();
    logic [7:0] mem [N][16];
    int         hd  [N];
    int         tl  [N];
    do_reset();
    for (int k = 0; k < N; k++) begin hd[k] = 0; tl[k] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        iv[k]   = 1'($urandom_range(0, 1));
        ordy[k] = 1'($urandom_range(0, 1));
        id[k]   = 8'($urandom);
      end
      sample();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (int'(cnt[k]) !== tl[k] - hd[k]) begin
          errors++; $display("FAIL rand_count[%0d] cyc%0d: got %0d want %0d", k, cyc, cnt[k], tl[k] - hd[k]);
        end
        if (ov[k]) begin
          checks++;
          if (tl[k] == hd[k] || od[k] !== mem[k][hd[k] % 16]) begin
            errors++; $display("FAIL rand_data[%0d] cyc%0d: got %h want %h (occ %0d)", k, cyc, od[k], mem[k][hd[k] % 16], tl[k] - hd[k]);
          end
        end
        if (iv[k] && ir[k]) begin
          mem[k][tl[k] % 16] = id[k];
          tl[k]++;
        end
        if (ov[k] && ordy[k] && tl[k] > hd[k]) hd[k]++;
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    do_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
